apb0_root_arbiter: RTL and testbench
====================================

APB0_ROOT_ARBITER -- requirements
Module: apb0_root_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd255: pclk_en-qualified ACCESS cycles before forced abort (used only under APB0_ARB_TIMEOUT_EN).
REQ-002 SHALL have port i_hclk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_hrst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_pclk_en  input  1  APB clock-enable; every APB phase advances only on i_hclk edges with i_pclk_en=1.
REQ-005 SHALL have, for N=0,1, ports i_mN_psel/i_mN_penable/i_mN_pwrite (1), i_mN_paddr (32), i_mN_pwdata (32), i_mN_pstrb (4), i_mN_pprot (3): inputs, APB master N request.
REQ-006 SHALL have, for N=0,1, ports o_mN_pready (1), o_mN_pslverr (1), o_mN_prdata (32): outputs, response to master N.
REQ-007 SHALL have ports o_root_psel, o_root_penable, o_root_pwrite (1), o_root_paddr (32), o_root_pwdata (32), o_root_pstrb (4), o_root_pprot (3): outputs, registered shared APB root bus.
REQ-008 SHALL have ports i_root_pready, i_root_pslverr (1), i_root_prdata (32): inputs, root bus response.

Function
REQ-009 SHALL implement one-hot FSM IDLE, SETUP, ACCESS.
REQ-010 Request N SHALL be i_mN_psel=1; arbitration occurs only in IDLE on an edge with i_pclk_en=1.
REQ-011 Single request: grant it; both: grant the master not granted last (round-robin, last_grant register).
REQ-012 On grant: latch winner's paddr/pwrite/pwdata/pstrb/pprot onto root outputs, drive o_root_psel=1, o_root_penable=0, go to SETUP.
REQ-013 SETUP with i_pclk_en=1: o_root_penable<=1, go to ACCESS; else hold SETUP.
REQ-014 ACCESS: o_mG_pready = i_root_pready & i_pclk_en & ACCESS; o_mG_pslverr = o_mG_pready & i_root_pslverr; o_mG_prdata = i_root_prdata (combinational, G = granted).
REQ-015 Non-granted master SHALL see pready=0, pslverr=0, prdata=0 at all times.
REQ-016 ACCESS with i_root_pready=1 and i_pclk_en=1: clear root psel/penable, update last_grant to G, go to IDLE; otherwise hold every root output stable.
REQ-017 Minimum latency: request sampled -> root SETUP 1 pclk -> ACCESS -> completion; master sees at least 2 pclk wait states.
REQ-018 Back-to-back: a new grant SHALL NOT issue on the completion edge; IDLE lasts at least one pclk_en edge.
REQ-019 If granted master drops psel mid-transfer (protocol violation), SHALL still complete root transfer and return to IDLE; response discarded.
REQ-020 o_root_paddr/pwdata/pstrb/pprot/pwrite SHALL change only on grant.

Reset
REQ-021 i_hrst=1 on an i_hclk edge SHALL force IDLE, all root outputs 0, last_grant=1 (master 0 wins first contention), timeout counter 0.
REQ-022 Reset mid-transfer SHALL drop o_root_psel/o_root_penable on that same edge; no pready returned to any master.
REQ-023 Reset is independent of i_pclk_en.

Configuration
REQ-024 With APB0_ARB_TIMEOUT_EN defined: an 8-bit counter increments on each i_pclk_en=1 edge in ACCESS while i_root_pready=0; clears in IDLE.
REQ-025 With it defined: when count reaches TIMEOUT_CYCLES with i_pclk_en=1, SHALL assert o_mG_pready=1, o_mG_pslverr=1, prdata=0 that cycle, clear root psel/penable, go to IDLE.
REQ-026 Without it: no counter; ACCESS waits indefinitely for i_root_pready.

Verification
REQ-027 pclk_en=1 always, m0 write addr 0x4000_0010 data 0xA5A5_5A5A pstrb 4'hF, pready=1 -> root SETUP then ACCESS with those values, o_m0_pready 1 cycle, m1 responses 0.
REQ-028 m0 and m1 request same edge after reset, held -> m0 granted first, m1 second, then m0 again (alternation).
REQ-029 pclk_en toggling 1/0, m1 read, root prdata 0x1234_5678 with pready low 3 pclk -> penable held, o_m1_prdata=0x1234_5678 on pready&pclk_en edge.
REQ-030 root pslverr=1 on completion of m0 read -> o_m0_pslverr=1 single cycle, FSM to IDLE.
REQ-031 i_hrst=1 in ACCESS -> next edge root psel=penable=0, IDLE, next contention granted to m0.
REQ-032 APB0_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> abort after 4 pclk_en ACCESS edges with pready=1, pslverr=1 to requester.

Source files
------------

// File: rtl/apb0_root_arbiter.sv
// Two-master round-robin APB arbiter onto one registered root bus; all APB phases advance on i_pclk_en.
// Optional ACCESS timeout abort is compiled in with APB0_ARB_TIMEOUT_EN.
module apb0_root_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        i_hclk,
  input  logic        i_hrst,
  input  logic        i_pclk_en,
  input  logic        i_m0_psel,
  input  logic        i_m0_penable,
  input  logic        i_m0_pwrite,
  input  logic [31:0] i_m0_paddr,
  input  logic [31:0] i_m0_pwdata,
  input  logic [3:0]  i_m0_pstrb,
  input  logic [2:0]  i_m0_pprot,
  input  logic        i_m1_psel,
  input  logic        i_m1_penable,
  input  logic        i_m1_pwrite,
  input  logic [31:0] i_m1_paddr,
  input  logic [31:0] i_m1_pwdata,
  input  logic [3:0]  i_m1_pstrb,
  input  logic [2:0]  i_m1_pprot,
  output logic        o_m0_pready,
  output logic        o_m0_pslverr,
  output logic [31:0] o_m0_prdata,
  output logic        o_m1_pready,
  output logic        o_m1_pslverr,
  output logic [31:0] o_m1_prdata,
  output logic        o_root_psel,
  output logic        o_root_penable,
  output logic        o_root_pwrite,
  output logic [31:0] o_root_paddr,
  output logic [31:0] o_root_pwdata,
  output logic [3:0]  o_root_pstrb,
  output logic [2:0]  o_root_pprot,
  input  logic        i_root_pready,
  input  logic        i_root_pslverr,
  input  logic [31:0] i_root_prdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_t;

  state_t state, state_nxt;
  logic   grant;       // 0 = master 0 owns the root bus
  logic   last_grant;
  logic   arb_go, arb_sel;
  logic   done, abort, gnt_psel, resp, rd_vld;

  // Master penable carries nothing the arbiter needs beyond psel.
  logic unused_penable;
  assign unused_penable = i_m0_penable ^ i_m1_penable;

  assign arb_go  = i_pclk_en & (i_m0_psel | i_m1_psel);
  assign arb_sel = (i_m0_psel & i_m1_psel) ? ~last_grant : i_m1_psel;
  assign done    = (state == ACCESS) & i_pclk_en & i_root_pready;

`ifdef APB0_ARB_TIMEOUT_EN
  logic [7:0] tcnt;

  assign abort = (state == ACCESS) & i_pclk_en & ~i_root_pready & (tcnt == TIMEOUT_CYCLES);

  always_ff @(posedge i_hclk) begin
    if (i_hrst || state != ACCESS) begin
      tcnt <= 8'd0;
    end else if (i_pclk_en && !i_root_pready && !abort) begin
      tcnt <= tcnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

  // A master that abandoned its request mid-transfer gets no response.
  assign gnt_psel = grant ? i_m1_psel : i_m0_psel;
  assign resp     = (done | abort) & gnt_psel;
  assign rd_vld   = (state == ACCESS) & gnt_psel & ~abort;

  assign o_m0_pready  = resp & ~grant;
  assign o_m1_pready  = resp & grant;
  assign o_m0_pslverr = o_m0_pready & (abort | i_root_pslverr);
  assign o_m1_pslverr = o_m1_pready & (abort | i_root_pslverr);
  assign o_m0_prdata  = (rd_vld & ~grant) ? i_root_prdata : 32'd0;
  assign o_m1_prdata  = (rd_vld & grant) ? i_root_prdata : 32'd0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_go) state_nxt = SETUP;
      SETUP:   if (i_pclk_en) state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (i_hrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hrst) begin
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      o_root_psel    <= 1'b0;
      o_root_penable <= 1'b0;
      o_root_pwrite  <= 1'b0;
      o_root_paddr   <= 32'd0;
      o_root_pwdata  <= 32'd0;
      o_root_pstrb   <= 4'd0;
      o_root_pprot   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            grant          <= arb_sel;
            o_root_psel    <= 1'b1;
            o_root_penable <= 1'b0;
            o_root_pwrite  <= arb_sel ? i_m1_pwrite : i_m0_pwrite;
            o_root_paddr   <= arb_sel ? i_m1_paddr  : i_m0_paddr;
            o_root_pwdata  <= arb_sel ? i_m1_pwdata : i_m0_pwdata;
            o_root_pstrb   <= arb_sel ? i_m1_pstrb  : i_m0_pstrb;
            o_root_pprot   <= arb_sel ? i_m1_pprot  : i_m0_pprot;
          end
        end
        SETUP: begin
          if (i_pclk_en) o_root_penable <= 1'b1;
        end
        ACCESS: begin
          if (done || abort) begin
            o_root_psel    <= 1'b0;
            o_root_penable <= 1'b0;
            last_grant     <= grant;
          end
        end
        default: begin
          o_root_psel    <= 1'b0;
          o_root_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb0_root_arbiter.sv
// Bench for apb0_root_arbiter: directed scenarios plus randomized batches against a transaction-order model.
module tb_apb0_root_arbiter;

`ifdef APB0_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'd4;
`else
  localparam logic [7:0] TMO = 8'd255;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pclk_en;
  logic [1:0]  psel, pwrite;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic [2:0]  pprot [2];
  logic [1:0]  m_pready, m_pslverr;
  logic [31:0] m_prdata [2];
  logic        r_psel, r_penable, r_pwrite;
  logic [31:0] r_paddr, r_pwdata;
  logic [3:0]  r_pstrb;
  logic [2:0]  r_pprot;
  logic        root_pready, root_pslverr;
  logic [31:0] root_prdata;

  apb0_root_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_hclk(clk), .i_hrst(rst), .i_pclk_en(pclk_en),
    .i_m0_psel(psel[0]), .i_m0_penable(1'b0), .i_m0_pwrite(pwrite[0]),
    .i_m0_paddr(paddr[0]), .i_m0_pwdata(pwdata[0]), .i_m0_pstrb(pstrb[0]), .i_m0_pprot(pprot[0]),
    .i_m1_psel(psel[1]), .i_m1_penable(1'b0), .i_m1_pwrite(pwrite[1]),
    .i_m1_paddr(paddr[1]), .i_m1_pwdata(pwdata[1]), .i_m1_pstrb(pstrb[1]), .i_m1_pprot(pprot[1]),
    .o_m0_pready(m_pready[0]), .o_m0_pslverr(m_pslverr[0]), .o_m0_prdata(m_prdata[0]),
    .o_m1_pready(m_pready[1]), .o_m1_pslverr(m_pslverr[1]), .o_m1_prdata(m_prdata[1]),
    .o_root_psel(r_psel), .o_root_penable(r_penable), .o_root_pwrite(r_pwrite),
    .o_root_paddr(r_paddr), .o_root_pwdata(r_pwdata), .o_root_pstrb(r_pstrb), .o_root_pprot(r_pprot),
    .i_root_pready(root_pready), .i_root_pslverr(root_pslverr), .i_root_prdata(root_prdata)
  );

  int          errs = 0, checks = 0;
  int          exp_q[$];
  int          last_served, en_mode, cfg_wait, waits_left, idle_en, acc_en, first_lat, cyc_cnt;
  logic        tog, prev_psel, gseen, cfg_err, cfg_tmo;
  logic [1:0]  drop;
  logic [31:0] cfg_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_txn(input int m);
    paddr[m]  = $urandom;
    pwdata[m] = $urandom;
    pstrb[m]  = 4'($urandom_range(15, 0));
    pprot[m]  = 3'($urandom_range(7, 0));
    pwrite[m] = 1'($urandom_range(1, 0));
  endtask

  // One hclk: drive inputs after the falling edge, then check the settled outputs.
  task automatic cyc();
    int h;
    @(negedge clk);
    for (int m = 0; m < 2; m++) if (drop[m]) begin psel[m] = 1'b0; drop[m] = 1'b0; end
    case (en_mode)
      0:       pclk_en = 1'b1;
      1:       begin tog = ~tog; pclk_en = tog; end
      default: pclk_en = 1'($urandom_range(1, 0));
    endcase
    if (r_penable && pclk_en) begin
      if (waits_left > 0) begin root_pready = 1'b0; waits_left--; end
      else root_pready = 1'b1;
      root_pslverr = cfg_err;
    end else begin
      root_pready  = 1'($urandom_range(1, 0));
      root_pslverr = 1'($urandom_range(1, 0));
    end
    root_prdata = r_penable ? cfg_rdata : $urandom;
    #1;
    cyc_cnt++;
    h = (exp_q.size() != 0) ? exp_q[0] : -1;
    if (r_psel && !prev_psel) begin
      chk("grant_pending", 32'(h >= 0), 32'd1);
      if (h >= 0) begin
        chk("grant_addr", r_paddr, paddr[h]);
        chk("grant_wdata", r_pwdata, pwdata[h]);
        chk("grant_ctl", {23'd0, r_pwrite, r_pstrb, r_pprot, r_penable}, {23'd0, pwrite[h], pstrb[h], pprot[h], 1'b0});
      end
      chk("idle_gap", 32'(idle_en != 0), 32'd1);
      gseen = 1'b1; idle_en = 0; acc_en = 0; waits_left = cfg_wait;
    end
    for (int m = 0; m < 2; m++) begin
      if (m != h) begin
        chk("ng_resp", {30'd0, m_pready[m], m_pslverr[m]}, 32'd0);
        chk("ng_rdata", m_prdata[m], 32'd0);
      end else if (m_pready[m]) begin
        chk("rsp_granted", 32'(gseen), 32'd1);
        chk("rsp_err", 32'(m_pslverr[m]), 32'(cfg_tmo | cfg_err));
        chk("rsp_rdata", m_prdata[m], cfg_tmo ? 32'd0 : cfg_rdata);
        chk("rsp_hold", {r_paddr[29:0], r_psel, r_penable}, {paddr[m][29:0], 2'b11});
        if (cfg_tmo) chk("tmo_edges", 32'(acc_en), 32'(TMO));
        if (first_lat < 0) first_lat = cyc_cnt;
        void'(exp_q.pop_front());
        last_served = m; drop[m] = 1'b1; gseen = 1'b0;
      end else if (r_penable) begin
        chk("acc_rdata", m_prdata[m], cfg_rdata);
      end
    end
    if (r_penable && pclk_en && !root_pready) acc_en++;
    if (!r_psel && pclk_en) idle_en++;
    prev_psel = r_psel;
  endtask

  task automatic run_batch(input logic r0, input logic r1);
    int f;
    if (r0 && r1) begin
      f = (last_served == 1) ? 0 : 1;
      exp_q.push_back(f);
      exp_q.push_back(1 - f);
    end else begin
      exp_q.push_back(r0 ? 0 : 1);
    end
    psel = {r1, r0};
    cyc_cnt = 0; first_lat = -1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc();
    chk("batch_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cyc();
  endtask

  initial begin
    rst = 1'b1; pclk_en = 1'b0; psel = 2'b00; drop = 2'b00;
    root_pready = 1'b0; root_pslverr = 1'b0; root_prdata = 32'd0;
    for (int m = 0; m < 2; m++) rand_txn(m);
    en_mode = 0; tog = 1'b0; prev_psel = 1'b0; gseen = 1'b0; last_served = 1;
    idle_en = 0; acc_en = 0; waits_left = 0; cfg_wait = 0; cfg_err = 1'b0; cfg_tmo = 1'b0; cfg_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_root_ctl", {20'd0, r_psel, r_penable, r_pwrite, r_pstrb, r_pprot}, 32'd0);
    chk("rst_root_addr", r_paddr | r_pwdata, 32'd0);
    chk("rst_m_pready", {30'd0, m_pready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    cyc(); cyc();

    // Single write from m0 with full strobes, zero-wait slave.
    paddr[0] = 32'h4000_0010; pwdata[0] = 32'hA5A5_5A5A; pstrb[0] = 4'hF; pwrite[0] = 1'b1; pprot[0] = 3'd0;
    cfg_rdata = $urandom;
    run_batch(1'b1, 1'b0);
    chk("min_latency", 32'(first_lat), 32'd2);

    // Reset while m1 sits in ACCESS against a stalled slave.
    rand_txn(1); cfg_wait = 1000; exp_q.push_back(1); psel = 2'b10;
    for (int i = 0; i < 20 && !r_penable; i++) cyc();
    chk("reach_access", 32'(r_penable), 32'd1);
    @(negedge clk); rst = 1'b1; pclk_en = 1'b0; root_pready = 1'b0;
    #1;
    chk("rst_mid_pready", {30'd0, m_pready}, 32'd0);
    @(negedge clk); rst = 1'b0; psel = 2'b00;
    #1;
    chk("rst_mid_root", {30'd0, r_psel, r_penable}, 32'd0);
    chk("rst_mid_pready2", {30'd0, m_pready}, 32'd0);
    exp_q.delete(); last_served = 1; prev_psel = 1'b0; gseen = 1'b0; drop = 2'b00; idle_en = 0; cfg_wait = 0;
    cyc();

    // Simultaneous requests alternate: m0, m1, then m0, m1 again.
    for (int b = 0; b < 2; b++) begin
      rand_txn(0); rand_txn(1); cfg_rdata = $urandom;
      run_batch(1'b1, 1'b1);
      chk("rr_last", 32'(last_served), 32'd1);
    end

    // m1 read with pclk_en toggling and three stalled ACCESS edges.
    en_mode = 1; rand_txn(1); pwrite[1] = 1'b0; cfg_rdata = 32'h1234_5678; cfg_wait = 3;
    run_batch(1'b0, 1'b1);

    // m0 read completing with a slave error.
    en_mode = 0; rand_txn(0); pwrite[0] = 1'b0; cfg_wait = 0; cfg_err = 1'b1; cfg_rdata = $urandom;
    run_batch(1'b1, 1'b0);
    chk("err_idle", {30'd0, r_psel, r_penable}, 32'd0);

    en_mode = 2;
    for (int b = 0; b < 40; b++) begin
      int rq;
      rq = $urandom_range(3, 1);
      rand_txn(0); rand_txn(1);
      cfg_wait = $urandom_range(3, 0); cfg_err = 1'($urandom_range(1, 0)); cfg_rdata = $urandom;
      run_batch(rq[0], rq[1]);
    end

`ifdef APB0_ARB_TIMEOUT_EN
    en_mode = 2; rand_txn(0); cfg_wait = 1000; cfg_err = 1'b0; cfg_tmo = 1'b1; cfg_rdata = $urandom;
    run_batch(1'b1, 1'b0);
    cfg_tmo = 1'b0; cfg_wait = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
